rsa_slot_wrapper: RTL and testbench
===================================

Name: rsa_slot_wrapper

Overview:
- Command-driven accelerator shell for the RSA project; successor to the single-register wrapper.
- Holds NUM_SLOTS operand registers of DATA_W bits.
- Decodes ARM commands from port1, moves data between BRAM/DMA and any slot, and performs a word-serial multi-cycle modular-2^DATA_W addition between slots.
- Reports completion and a status word on port2; sits between the ARM/DMA interface and future Montgomery cores.

Parameters:
DATA_W, 1024, operand width in bits; must be a multiple of WORD_W
WORD_W, 64, adder datapath width per cycle
NUM_SLOTS, 4, number of operand registers (1..16)

Ports:
clk  in  1  clock, all logic on rising edge
resetn  in  1  synchronous, active-low reset
bram_din  in  DATA_W  data from DMA/BRAM
bram_din_valid  in  1  bram_din valid this cycle
bram_dout  out  DATA_W  selected slot contents for writeback
bram_dout_valid  out  1  bram_dout holds valid data
bram_dout_read  in  1  BRAM interface consumed bram_dout
port1_din  in  32  command word
port1_valid  in  1  command available
port1_read  out  1  one-cycle acknowledge of a command
port2_valid  out  1  operation done, status on port2_dout
port2_dout  out  32  status word
port2_read  in  1  ARM consumed status
leds  out  4  {err_flag, state[2:0]}

Behaviour:
- Command fields:
  - [3:0] opcode
  - [11:8] dst slot
  - [19:16] srcA slot
  - [27:24] srcB slot
  - other bits ignored
- Opcodes:
  - 0 READ: bram_din -> slot[dst]
  - 1 ADD: slot[dst] = (slot[srcA] + slot[srcB]) mod 2^DATA_W
  - 2 WRITE: slot[srcA] -> bram_dout
  - 3 CLEAR: slot[dst] = 0
- States: IDLE, READ, ADD, WRITE, DONE.
- IDLE:
  - When port1_valid=1, latch the command and assert port1_read the next cycle for exactly one cycle.
  - Next state is chosen by opcode.
  - Error goes straight to DONE with err=1 and no slot modified. Error cases: opcode >3, or any used slot index >= NUM_SLOTS.
- READ:
  - Wait for bram_din_valid. On that cycle capture bram_din into slot[dst], then go to DONE.
  - bram_din is ignored in every other state.
- ADD:
  - NWORDS = DATA_W/WORD_W; word counter 0..NWORDS-1; carry register cleared on entry.
  - Each cycle i: dst word i = A word i + B word i + carry, and carry updates.
  - After word NWORDS-1, go to DONE with carry_out = final carry.
  - Latency: exactly NWORDS cycles in ADD (16 at defaults).
  - dst may equal srcA and/or srcB; the result must be correct because word i of the sources is read before word i is overwritten.
- CLEAR: one cycle, then DONE.
- WRITE:
  - bram_dout = slot[srcA].
  - bram_dout_valid is registered: it asserts the cycle after entering WRITE and holds until bram_dout_read=1.
  - On read, go to DONE; bram_dout_valid drops the following cycle.
- DONE:
  - port2_valid is registered: it rises the cycle after entering DONE and holds until port2_read=1, then returns to IDLE.
  - port2_dout is stable while port2_valid=1: [3:0] opcode echo, [8] err, [9] carry_out (ADD only, else 0), rest 0.
- New commands are accepted only in IDLE; port1_valid in other states is ignored and port1_read stays 0.
- bram_dout always reflects the last WRITE-selected slot (0 after reset).
- Reset, including mid-operation:
  - state = IDLE; all slots cleared to 0.
  - port1_read = 0, port2_valid = 0, bram_dout_valid = 0, port2_dout = 0, leds = 0.
  - An in-flight ADD is abandoned and its partial result discarded (slots cleared).
- err_flag (leds[3]) is sticky: set by any error, cleared only by reset.

Test Plan:
- READ dst=2 with bram_din=0x0123…EF, then WRITE srcA=2 -> bram_dout equals pattern; port1_read pulses 1 cycle per command; status opcode=0/2, err=0.
- slot0=2^1024-1, slot1=1, ADD dst=3 srcA=0 srcB=1 -> slot3=0, carry_out=1, port2_valid 17 cycles after port1_read at WORD_W=64.
- Aliased ADD dst=0 srcA=0 srcB=0 with slot0=0x8000…0001 -> slot0=0x0000…0002, carry=1.
- Opcode 7, and separately READ dst=5 with NUM_SLOTS=4 -> no slot change, status err=1, leds[3]=1 until reset.
- Hold port2_read=0 for 10 cycles -> port2_valid and port2_dout stable; a port1_valid pulse in that window is not acknowledged.
- Assert resetn=0 at ADD word 7 -> next cycle state IDLE, all outputs 0; a subsequent WRITE of any slot returns 0.

Source files
------------

// File: rtl/rsa_slot_if.sv
// ARM command/status and BRAM/DMA data bundle for the RSA slot wrapper.
// "master" is the ARM/DMA side; "slave" is the wrapper.
interface rsa_slot_if #(
   parameter int DATA_W = 1024
);
   logic [DATA_W-1:0] bram_din;
   logic              bram_din_valid;
   logic [DATA_W-1:0] bram_dout;
   logic              bram_dout_valid;
   logic              bram_dout_read;
   logic [31:0]       port1_din;
   logic              port1_valid;
   logic              port1_read;
   logic              port2_valid;
   logic [31:0]       port2_dout;
   logic              port2_read;

   modport master (
      output bram_din, bram_din_valid, bram_dout_read, port1_din, port1_valid, port2_read,
      input  bram_dout, bram_dout_valid, port1_read, port2_valid, port2_dout
   );

   modport slave (
      input  bram_din, bram_din_valid, bram_dout_read, port1_din, port1_valid, port2_read,
      output bram_dout, bram_dout_valid, port1_read, port2_valid, port2_dout
   );
endinterface

// File: rtl/rsa_slot_wrapper.sv
// Command-driven operand slot shell: BRAM load/store, clear, and word-serial
// modular addition between slots, with status reported on port2.
//
// state   | meaning
// S_IDLE  | waiting for a command on port1
// S_READ  | waiting for bram_din_valid to load slot[dst]
// S_ADD   | one WORD_W slice of slot[srcA]+slot[srcB] per cycle into slot[dst]
// S_WRITE | presenting slot[srcA] on bram_dout until consumed
// S_CLEAR | zeroing slot[dst]
// S_DONE  | holding status on port2 until read
module rsa_slot_wrapper #(
   parameter int DATA_W    = 1024,
   parameter int WORD_W    = 64,
   parameter int NUM_SLOTS = 4
) (
   input  logic       clk,
   input  logic       resetn,
   rsa_slot_if.slave  bus,
   output logic [3:0] leds
);
   localparam int NWORDS = DATA_W / WORD_W;
   localparam int CNT_W  = (NWORDS > 1) ? $clog2(NWORDS) : 1;
   localparam int SLOT_W = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_READ  = 3'd1,
      S_ADD   = 3'd2,
      S_WRITE = 3'd3,
      S_DONE  = 3'd4,
      S_CLEAR = 3'd5
   } state_t;

   typedef logic [NWORDS-1:0][WORD_W-1:0] operand_t;

   state_t              state_q, state_d;
   logic [3:0]          op_q, op_d;
   logic [SLOT_W-1:0]   dst_q, dst_d;
   logic [SLOT_W-1:0]   srca_q, srca_d;
   logic [SLOT_W-1:0]   srcb_q, srcb_d;
   logic [CNT_W-1:0]    wcnt_q, wcnt_d;
   logic                carry_q, carry_d;
   logic                port1_read_q, port1_read_d;
   logic                port2_valid_q, port2_valid_d;
   logic [31:0]         status_q, status_d;
   operand_t            dout_q, dout_d;
   logic                dout_valid_q, dout_valid_d;
   logic                err_flag_q, err_flag_d;
   operand_t            slot_q [NUM_SLOTS];
   operand_t            slot_d [NUM_SLOTS];

   logic                cmd_err;
   logic [WORD_W:0]     word_sum;
   logic                unused_cmd_bits;

   assign unused_cmd_bits = ^{bus.port1_din[31:28], bus.port1_din[23:20],
                              bus.port1_din[15:12], bus.port1_din[7:4]};

   function automatic logic bad_slot(input logic [3:0] idx);
      return ({1'b0, idx} >= 5'(NUM_SLOTS));
   endfunction

   function automatic logic [31:0] make_status(input logic [3:0] op, input logic err,
                                               input logic cout);
      return {22'd0, cout, err, 4'd0, op};
   endfunction

   always_comb begin
      state_d       = state_q;
      op_d          = op_q;
      dst_d         = dst_q;
      srca_d        = srca_q;
      srcb_d        = srcb_q;
      wcnt_d        = wcnt_q;
      carry_d       = carry_q;
      port1_read_d  = 1'b0;
      port2_valid_d = port2_valid_q;
      status_d      = status_q;
      dout_d        = dout_q;
      dout_valid_d  = dout_valid_q;
      err_flag_d    = err_flag_q;
      slot_d        = slot_q;
      cmd_err       = 1'b0;
      word_sum      = '0;

      unique case (state_q)
         S_IDLE: begin
            if (bus.port1_valid) begin
               port1_read_d = 1'b1;
               op_d         = bus.port1_din[3:0];
               dst_d        = bus.port1_din[8 +: SLOT_W];
               srca_d       = bus.port1_din[16 +: SLOT_W];
               srcb_d       = bus.port1_din[24 +: SLOT_W];
               wcnt_d       = '0;
               carry_d      = 1'b0;
               case (bus.port1_din[3:0])
                  4'd0: begin
                     cmd_err = bad_slot(bus.port1_din[11:8]);
                     state_d = S_READ;
                  end
                  4'd1: begin
                     cmd_err = bad_slot(bus.port1_din[11:8]) | bad_slot(bus.port1_din[19:16])
                             | bad_slot(bus.port1_din[27:24]);
                     state_d = S_ADD;
                  end
                  4'd2: begin
                     cmd_err = bad_slot(bus.port1_din[19:16]);
                     state_d = S_WRITE;
                  end
                  4'd3: begin
                     cmd_err = bad_slot(bus.port1_din[11:8]);
                     state_d = S_CLEAR;
                  end
                  default: cmd_err = 1'b1;
               endcase
               if (cmd_err) begin
                  state_d    = S_DONE;
                  err_flag_d = 1'b1;
                  status_d   = make_status(bus.port1_din[3:0], 1'b1, 1'b0);
               end
            end
         end
         S_READ: begin
            if (bus.bram_din_valid) begin
               slot_d[dst_q] = bus.bram_din;
               state_d       = S_DONE;
               status_d      = make_status(op_q, 1'b0, 1'b0);
            end
         end
         S_ADD: begin
            // Word i of both sources is read from the current slots before the
            // same word of dst is replaced, so aliased slots stay correct.
            word_sum = {1'b0, slot_q[srca_q][wcnt_q]} + {1'b0, slot_q[srcb_q][wcnt_q]}
                     + (WORD_W+1)'(carry_q);
            slot_d[dst_q][wcnt_q] = word_sum[WORD_W-1:0];
            carry_d = word_sum[WORD_W];
            wcnt_d  = wcnt_q + CNT_W'(1);
            if (wcnt_q == CNT_W'(NWORDS-1)) begin
               state_d  = S_DONE;
               status_d = make_status(op_q, 1'b0, word_sum[WORD_W]);
            end
         end
         S_WRITE: begin
            if (!dout_valid_q) begin
               dout_d       = slot_q[srca_q];
               dout_valid_d = 1'b1;
            end else if (bus.bram_dout_read) begin
               dout_valid_d = 1'b0;
               state_d      = S_DONE;
               status_d     = make_status(op_q, 1'b0, 1'b0);
            end
         end
         S_CLEAR: begin
            slot_d[dst_q] = '0;
            state_d       = S_DONE;
            status_d      = make_status(op_q, 1'b0, 1'b0);
         end
         S_DONE: begin
            if (port2_valid_q && bus.port2_read) begin
               port2_valid_d = 1'b0;
               state_d       = S_IDLE;
            end else begin
               port2_valid_d = 1'b1;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         state_q       <= S_IDLE;
         op_q          <= '0;
         dst_q         <= '0;
         srca_q        <= '0;
         srcb_q        <= '0;
         wcnt_q        <= '0;
         carry_q       <= 1'b0;
         port1_read_q  <= 1'b0;
         port2_valid_q <= 1'b0;
         status_q      <= '0;
         dout_q        <= '0;
         dout_valid_q  <= 1'b0;
         err_flag_q    <= 1'b0;
         slot_q        <= '{default: '0};
      end else begin
         state_q       <= state_d;
         op_q          <= op_d;
         dst_q         <= dst_d;
         srca_q        <= srca_d;
         srcb_q        <= srcb_d;
         wcnt_q        <= wcnt_d;
         carry_q       <= carry_d;
         port1_read_q  <= port1_read_d;
         port2_valid_q <= port2_valid_d;
         status_q      <= status_d;
         dout_q        <= dout_d;
         dout_valid_q  <= dout_valid_d;
         err_flag_q    <= err_flag_d;
         slot_q        <= slot_d;
      end
   end

   assign bus.port1_read      = port1_read_q;
   assign bus.port2_valid     = port2_valid_q;
   assign bus.port2_dout      = status_q;
   assign bus.bram_dout       = dout_q;
   assign bus.bram_dout_valid = dout_valid_q;
   assign leds                = {err_flag_q, state_q};
endmodule

// File: tb/tb_rsa_slot_wrapper.sv
// Bench for rsa_slot_wrapper: directed cases plus random command stream
// compared against a whole-operand arithmetic model of the slots.
module tb_rsa_slot_wrapper;
   localparam int DATA_W    = 1024;
   localparam int WORD_W    = 64;
   localparam int NUM_SLOTS = 4;
   localparam int NWORDS    = DATA_W / WORD_W;

   typedef logic [DATA_W-1:0] op_t;

   logic       clk = 1'b0;
   logic       resetn = 1'b0;
   logic [3:0] leds;

   rsa_slot_if #(.DATA_W(DATA_W)) bus ();

   rsa_slot_wrapper #(.DATA_W(DATA_W), .WORD_W(WORD_W), .NUM_SLOTS(NUM_SLOTS)) dut (
      .clk    (clk),
      .resetn (resetn),
      .bus    (bus),
      .leds   (leds)
   );

   always #5 clk = ~clk;

   int   n_checks = 0;
   int   n_fail   = 0;
   op_t  model_slot [NUM_SLOTS];
   op_t  model_dout;
   logic model_err;

   task automatic chk(input string tag, input op_t got, input op_t exp);
      n_checks++;
      if (got !== exp) begin
         int w;
         w = 0;
         for (int i = NWORDS-1; i >= 0; i--)
            if (got[i*WORD_W +: WORD_W] !== exp[i*WORD_W +: WORD_W]) w = i;
         n_fail++;
         $display("FAIL %s word=%0d got=%h exp=%h", tag, w,
                  got[w*WORD_W +: WORD_W], exp[w*WORD_W +: WORD_W]);
      end
   endtask

   function automatic op_t rand_op();
      op_t v;
      for (int i = 0; i < DATA_W/32; i++) v[i*32 +: 32] = $urandom;
      return v;
   endfunction

   task automatic model_clear();
      for (int s = 0; s < NUM_SLOTS; s++) model_slot[s] = '0;
      model_dout = '0;
      model_err  = 1'b0;
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_leds"},       op_t'(leds), op_t'(0));
      chk({tag, "_p1_read"},    op_t'(bus.port1_read), op_t'(0));
      chk({tag, "_p2_valid"},   op_t'(bus.port2_valid), op_t'(0));
      chk({tag, "_dout_valid"}, op_t'(bus.bram_dout_valid), op_t'(0));
      chk({tag, "_p2_dout"},    op_t'(bus.port2_dout), op_t'(0));
      chk({tag, "_bram_dout"},  bus.bram_dout, op_t'(0));
   endtask

   task automatic do_reset();
      resetn = 1'b0;
      repeat (2) @(negedge clk);
      chk_reset_outputs("reset");
      resetn = 1'b1;
      model_clear();
   endtask

   // One full command transaction, including the status handshake.
   task automatic run_cmd(input logic [3:0] op, input int dst, input int a, input int b,
                          input op_t din, input int hold);
      logic [31:0]    cmd;
      logic [31:0]    st;
      logic           cerr;
      logic           exp_cout;
      logic [DATA_W:0] sum;
      int             lat;
      int             exp_lat;

      cmd        = $urandom;
      cmd[3:0]   = op;
      cmd[11:8]  = dst[3:0];
      cmd[19:16] = a[3:0];
      cmd[27:24] = b[3:0];
      exp_cout   = 1'b0;
      case (op)
         4'd0:    cerr = (dst >= NUM_SLOTS);
         4'd1:    cerr = (dst >= NUM_SLOTS) || (a >= NUM_SLOTS) || (b >= NUM_SLOTS);
         4'd2:    cerr = (a >= NUM_SLOTS);
         4'd3:    cerr = (dst >= NUM_SLOTS);
         default: cerr = 1'b1;
      endcase
      if (cerr)          exp_lat = 1;
      else if (op == 1)  exp_lat = NWORDS + 1;
      else if (op == 3)  exp_lat = 2;
      else               exp_lat = -1;

      @(negedge clk);
      bus.port1_din      = cmd;
      bus.port1_valid    = 1'b1;
      bus.bram_din       = rand_op();
      bus.bram_din_valid = 1'b1;
      @(negedge clk);
      bus.port1_valid    = 1'b0;
      bus.bram_din_valid = 1'b0;
      chk("p1_read_hi", op_t'(bus.port1_read), op_t'(1));
      @(negedge clk);
      chk("p1_read_lo", op_t'(bus.port1_read), op_t'(0));
      lat = 1;

      if (!cerr) begin
         case (op)
            4'd0: begin
               repeat ($urandom_range(0, 3)) @(negedge clk);
               bus.bram_din       = din;
               bus.bram_din_valid = 1'b1;
               @(negedge clk);
               bus.bram_din_valid = 1'b0;
               bus.bram_din       = rand_op();
               model_slot[dst]    = din;
            end
            4'd1: begin
               sum = {1'b0, model_slot[a]} + {1'b0, model_slot[b]};
               model_slot[dst] = sum[DATA_W-1:0];
               exp_cout        = sum[DATA_W];
            end
            4'd2: begin
               for (int i = 0; i < 20 && !bus.bram_dout_valid; i++) @(negedge clk);
               model_dout = model_slot[a];
               chk("dout_valid", op_t'(bus.bram_dout_valid), op_t'(1));
               chk("bram_dout", bus.bram_dout, model_dout);
               repeat ($urandom_range(0, 3)) begin
                  @(negedge clk);
                  chk("dout_valid_hold", op_t'(bus.bram_dout_valid), op_t'(1));
               end
               bus.bram_dout_read = 1'b1;
               @(negedge clk);
               bus.bram_dout_read = 1'b0;
               chk("dout_valid_drop", op_t'(bus.bram_dout_valid), op_t'(0));
               chk("bram_dout_keep", bus.bram_dout, model_dout);
            end
            default: model_slot[dst] = '0;
         endcase
      end

      while (!bus.port2_valid && lat < 200) begin
         @(negedge clk);
         lat++;
      end
      chk("p2_valid", op_t'(bus.port2_valid), op_t'(1));
      if (exp_lat > 0) chk("p2_latency", op_t'(lat), op_t'(exp_lat));
      st = {22'd0, exp_cout, cerr, 4'd0, op};
      if (cerr) model_err = 1'b1;
      chk("status", op_t'(bus.port2_dout), op_t'(st));
      chk("err_led", op_t'(leds[3]), op_t'(model_err));

      for (int i = 0; i < hold; i++) begin
         @(negedge clk);
         bus.port1_valid = 1'b0;
         chk("p2_hold_valid", op_t'(bus.port2_valid), op_t'(1));
         chk("p2_hold_dout", op_t'(bus.port2_dout), op_t'(st));
         chk("p1_ignored", op_t'(bus.port1_read), op_t'(0));
         if (i == 0 && hold > 1) begin
            bus.port1_din   = $urandom;
            bus.port1_valid = 1'b1;
         end
      end
      bus.port1_valid = 1'b0;
      bus.port2_read  = 1'b1;
      @(negedge clk);
      bus.port2_read  = 1'b0;
      chk("p2_drop", op_t'(bus.port2_valid), op_t'(0));
      chk("idle_state", op_t'(leds[2:0]), op_t'(0));
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      op_t pat;
      op_t v;
      int  r;
      int  d;
      int  sa;
      int  sb;

      bus.bram_din       = '0;
      bus.bram_din_valid = 1'b0;
      bus.bram_dout_read = 1'b0;
      bus.port1_din      = '0;
      bus.port1_valid    = 1'b0;
      bus.port2_read     = 1'b0;
      model_clear();
      do_reset();

      for (int i = 0; i < NWORDS; i++) pat[i*WORD_W +: WORD_W] = 64'h0123_4567_89AB_CDEF;
      run_cmd(4'd0, 2, 0, 0, pat, 0);
      run_cmd(4'd2, 0, 2, 0, '0, 3);

      run_cmd(4'd0, 0, 0, 0, '1, 0);
      run_cmd(4'd0, 1, 0, 0, op_t'(1), 0);
      run_cmd(4'd1, 3, 0, 1, '0, 1);
      run_cmd(4'd2, 0, 3, 0, '0, 0);

      v = '0;
      v[DATA_W-1] = 1'b1;
      v[0] = 1'b1;
      run_cmd(4'd0, 0, 0, 0, v, 0);
      run_cmd(4'd1, 0, 0, 0, '0, 2);
      run_cmd(4'd2, 0, 0, 0, '0, 0);

      run_cmd(4'd7, 0, 0, 0, '0, 0);
      run_cmd(4'd0, 5, 0, 0, rand_op(), 10);
      for (int s = 0; s < NUM_SLOTS; s++) run_cmd(4'd2, 0, s, 0, '0, 0);

      for (int n = 0; n < 40; n++) begin
         r  = $urandom_range(0, 9);
         d  = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 15) : $urandom_range(0, NUM_SLOTS-1);
         sa = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 15) : $urandom_range(0, NUM_SLOTS-1);
         sb = $urandom_range(0, NUM_SLOTS-1);
         if (r <= 2)      run_cmd(4'd0, d, sa, sb, rand_op(), $urandom_range(0, 3));
         else if (r <= 5) run_cmd(4'd1, d, sa, sb, '0, $urandom_range(0, 3));
         else if (r <= 7) run_cmd(4'd2, d, sa, sb, '0, $urandom_range(0, 3));
         else if (r == 8) run_cmd(4'd3, d, sa, sb, '0, $urandom_range(0, 3));
         else             run_cmd(4'($urandom_range(4, 15)), d, sa, sb, '0, $urandom_range(0, 3));
      end

      // Reset in the middle of an ADD, with non-zero slots and bram_dout.
      run_cmd(4'd0, 0, 0, 0, rand_op(), 0);
      run_cmd(4'd0, 1, 0, 0, rand_op(), 0);
      run_cmd(4'd2, 0, 0, 0, '0, 0);
      @(negedge clk);
      bus.port1_din   = 32'h0100_0201;
      bus.port1_valid = 1'b1;
      @(negedge clk);
      bus.port1_valid = 1'b0;
      repeat (7) @(negedge clk);
      resetn = 1'b0;
      @(negedge clk);
      chk_reset_outputs("midadd");
      resetn = 1'b1;
      model_clear();
      for (int s = 0; s < NUM_SLOTS; s++) run_cmd(4'd2, 0, s, 0, '0, 0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end
endmodule
